pf_lanectrl_pause_sequencer: RTL and testbench

Arbitrates and sequences access to the lane controller's HS_IO_CLK_PAUSE input among several requesters: DQS/DLL delay-code updates, write-leveling, read-gate training and periodic calibration. The sequencer runs in the fabric clock domain and drives HS_IO_CLK_PAUSE into the lane-control pause synchronizer. It gives each requester a pause window framed by setup, hold and guard intervals, so the high-speed I/O clock is stopped before any delay code is changed and a restart is never back-to-back.

---
 rtl/pf_lanectrl_pause_sequencer.sv | 148 ++++++++++++++
 tb/tb_pf_lanectrl_pause_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pf_lanectrl_pause_sequencer.sv
// Round-robin sequencer for the lane controller's HS_IO_CLK_PAUSE input.
// Each grant is framed by setup, hold and guard intervals so the I/O clock is stopped around delay-code changes.
module pf_lanectrl_pause_sequencer #(
    parameter int NUM_REQ        = 4,
    parameter int SETUP_CYCLES   = 3,
    parameter int HOLD_CYCLES    = 2,
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_REQ-1:0] REQ,
    output logic [NUM_REQ-1:0] GNT,
    output logic               HS_IO_CLK_PAUSE,
    output logic               BUSY,
    output logic               TIMEOUT_ERR,
    output logic [2:0]         TIMEOUT_ID
);

    // Handshake: REQ is a level held by the requester until its work is done; GNT is the
    // one-hot answer, and only REQ of the current winner is observed while a window is open.

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        GRANT,
        HOLD,
        GUARD
    } state_t;

    state_t             state;
    logic [7:0]         cnt;
    logic [2:0]         ptr;
    logic [2:0]         win;
    logic [NUM_REQ-1:0] win_oh;

    logic               any_valid;
    logic               hi_valid;
    logic [2:0]         any_idx;
    logic [2:0]         hi_idx;
    logic [2:0]         pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic               req_win;
    logic [2:0]         ptr_next;

    // Lowest set bit at or above the pointer wins; otherwise wrap to the lowest set bit overall.
    always_comb begin
        any_valid = 1'b0;
        hi_valid  = 1'b0;
        any_idx   = '0;
        hi_idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (REQ[k]) begin
                any_valid = 1'b1;
                any_idx   = 3'(k);
                if (k >= int'(ptr)) begin
                    hi_valid = 1'b1;
                    hi_idx   = 3'(k);
                end
            end
        end
        pick_idx = hi_valid ? hi_idx : any_idx;
        pick_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
    end

    assign req_win  = |(REQ & win_oh);
    assign ptr_next = (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state           <= IDLE;
            cnt             <= '0;
            ptr             <= '0;
            win             <= '0;
            win_oh          <= '0;
            GNT             <= '0;
            HS_IO_CLK_PAUSE <= 1'b0;
            BUSY            <= 1'b0;
            TIMEOUT_ERR     <= 1'b0;
            TIMEOUT_ID      <= '0;
        end else begin
            TIMEOUT_ERR <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        win             <= pick_idx;
                        win_oh          <= pick_oh;
                        HS_IO_CLK_PAUSE <= 1'b1;
                        BUSY            <= 1'b1;
                        cnt             <= 8'(SETUP_CYCLES - 1);
                        state           <= SETUP;
                    end
                end
                SETUP: begin
                    // The grant is issued even if the winner already withdrew.
                    if (cnt == 8'd0) begin
                        GNT   <= win_oh;
                        cnt   <= 8'(TIMEOUT_CYCLES - 1);
                        state <= GRANT;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GRANT: begin
                    if (!req_win) begin
                        GNT   <= '0;
                        ptr   <= ptr_next;
                        cnt   <= 8'(HOLD_CYCLES - 1);
                        state <= HOLD;
                    end else if (cnt == 8'd0) begin
                        GNT         <= '0;
                        ptr         <= ptr_next;
                        TIMEOUT_ERR <= 1'b1;
                        TIMEOUT_ID  <= win;
                        cnt         <= 8'(HOLD_CYCLES - 1);
                        state       <= HOLD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 8'd0) begin
                        HS_IO_CLK_PAUSE <= 1'b0;
                        cnt             <= 8'(GUARD_CYCLES - 1);
                        state           <= GUARD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GUARD: begin
                    if (cnt == 8'd0) begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    GNT             <= '0;
                    HS_IO_CLK_PAUSE <= 1'b0;
                    BUSY            <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pf_lanectrl_pause_sequencer.sv
// Bench for pf_lanectrl_pause_sequencer: directed table, hand sequences and a
// timeline-based reference model driven by random request traffic.
module tb_pf_lanectrl_pause_sequencer;

    localparam int N = 4;
    localparam int S = 3;
    localparam int H = 2;
    localparam int G = 4;
    localparam int T = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         pause;
    logic         busy;
    logic         terr;
    logic [2:0]   tid;

    int checks = 0;
    int errors = 0;

    pf_lanectrl_pause_sequencer #(
        .NUM_REQ(N), .SETUP_CYCLES(S), .HOLD_CYCLES(H),
        .GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK(clk), .RESET(rst), .REQ(req), .GNT(gnt),
        .HS_IO_CLK_PAUSE(pause), .BUSY(busy),
        .TIMEOUT_ERR(terr), .TIMEOUT_ID(tid)
    );

    always #5 clk = ~clk;

    // Reference model: a window is described by its start edge t0 and end edge e;
    // every output is a function of the current edge number relative to those.
    int           m_now;
    bit           m_active;
    int           m_t0;
    int           m_e;
    bit           m_to;
    int           m_win;
    int           m_ptr;
    int           m_tid;
    logic [N-1:0] e_gnt;
    logic         e_pause;
    logic         e_busy;
    logic         e_terr;
    logic [2:0]   e_tid;

    int           low_run;
    logic         prev_pause;
    int           terr_cnt;
    logic [N-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        logic [N-1:0] sh;
        for (int i = 0; i < N; i++) begin
            sh = r >> ((p + i) % N);
            if (sh[0]) return (p + i) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_active = 0; m_ptr = 0; m_tid = 0; m_e = -1; m_to = 0;
        e_gnt = '0; e_pause = 0; e_busy = 0; e_terr = 0; e_tid = '0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        int           n;
        logic [N-1:0] sh;
        m_now++;
        n = m_now;
        if (!m_active) begin
            if (r != 0) begin
                m_active = 1; m_t0 = n; m_e = -1; m_to = 0;
                m_win = rr_pick(r, m_ptr);
            end
        end else if (m_e < 0) begin
            if (n > m_t0 + S) begin
                sh = r >> m_win;
                if (!sh[0]) m_e = n;
                else if (n == m_t0 + S + T) begin
                    m_e = n; m_to = 1; m_tid = m_win;
                end
                if (m_e == n) m_ptr = (m_win + 1) % N;
            end
        end else if (n == m_e + H + G) begin
            m_active = 0;
        end
        e_busy  = m_active;
        e_pause = m_active && (m_e < 0 || n < m_e + H);
        e_gnt   = (m_active && m_e < 0 && n >= m_t0 + S) ? (N'(1) << m_win) : '0;
        e_terr  = m_active && m_to && (m_e == n);
        e_tid   = 3'(m_tid);
    endtask

    // Called at a negedge: drive REQ, let one edge pass, compare, return at the next negedge.
    task automatic tick(input logic [N-1:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
        chk("m_gnt", gnt, e_gnt);
        chk("m_pause", pause, e_pause);
        chk("m_busy", busy, e_busy);
        chk("m_terr", terr, e_terr);
        chk("m_tid", tid, e_tid);
        chk("inv_onehot", $onehot0(gnt), 1);
        chk("inv_gnt_pause", (gnt == 0) || pause, 1);
        if (pause) begin
            if (!prev_pause) chk("inv_gap", low_run >= G + 1, 1);
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_pause = pause;
        if (terr) terr_cnt++;
        @(negedge clk);
    endtask

    task automatic wait_gnt(input logic [N-1:0] r, input bit want, input int budget,
                            input string name, output int used);
        used = 0;
        while (((gnt != 0) != want) && used < budget) begin
            tick(r);
            used++;
        end
        chk(name, gnt != 0, want);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_pause", pause, 0);
        chk("rst_busy", busy, 0);
        chk("rst_terr", terr, 0);
        chk("rst_tid", tid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        low_run = 1000;
        prev_pause = 0;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic         pause;
        logic         busy;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int           used;
        int           cnt;
        int           terr_before;
        logic [N-1:0] drop;
        logic [N-1:0] pg;
        logic [N-1:0] exp;
        logic [N-1:0] r;
        int           age;

        for (int n = 0; n < 18; n++) begin
            vecs[n].req   = (n <= 9) ? 4'b0010 : 4'b0000;
            vecs[n].gnt   = (n >= 3 && n <= 9) ? 4'b0010 : 4'b0000;
            vecs[n].pause = (n <= 11);
            vecs[n].busy  = (n <= 15);
        end

        rst = 1'b0; req = '0; m_now = 0; terr_cnt = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single request: edge-by-edge against the table.
        for (int n = 0; n < 18; n++) begin
            tick(vecs[n].req);
            chk("tbl_gnt", gnt, vecs[n].gnt);
            chk("tbl_pause", pause, vecs[n].pause);
            chk("tbl_busy", busy, vecs[n].busy);
        end

        // Early withdrawal during SETUP still yields exactly one GNT cycle.
        terr_before = terr_cnt;
        cnt = 0;
        tick(4'b0001);
        for (int i = 0; i < 20; i++) begin
            tick(4'b0000);
            if (gnt[0]) cnt++;
        end
        chk("early_gnt_cycles", cnt, 1);
        chk("early_no_terr", terr_cnt - terr_before, 0);
        chk("early_idle", busy, 0);

        // Timeout on requester 2, then requester 3 wins the next window.
        terr_before = terr_cnt;
        wait_gnt(4'b0100, 1, 10, "to_grant", used);
        chk("to_grant_id", gnt, 4'b0100);
        wait_gnt(4'b0100, 0, 20, "to_end", used);
        chk("to_len", used, T);
        wait_gnt(4'b1100, 1, 20, "to_next", used);
        chk("to_next_id", gnt, 4'b1000);
        chk("to_pulses", terr_cnt - terr_before, 1);
        chk("to_tid", tid, 2);
        wait_gnt(4'b0100, 0, 20, "to_next_end", used);
        wait_gnt(4'b0100, 1, 30, "to_regrant", used);
        chk("to_regrant_id", gnt, 4'b0100);

        // Reset in the middle of a grant, then pointer restarts at 0.
        do_reset();
        wait_gnt(4'b1010, 1, 20, "rst_regrant", used);
        chk("rst_regrant_id", gnt, 4'b0010);
        chk("rst_latency", used, S + 1);
        repeat (12) tick(4'b0000);

        // Round robin with all requesters active.
        do_reset();
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        drop = '0; pg = '0; age = 0;
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
            tick(4'b1111 & ~drop);
            if (gnt != 0) begin
                if (pg == 0) begin
                    exp = exp_q.pop_front();
                    chk("rr_order", gnt, exp);
                    age = 0;
                end
                age++;
                if (age == 2) drop = drop | gnt;
            end
            if (busy && !pause) drop = '0;
            pg = gnt;
        end
        chk("rr_all_granted", exp_q.size(), 0);

        // Random traffic against the model and invariants.
        r = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            tick(r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
